// File: rtl/mux2_way_pkg.sv
// Shared definitions for the two-mode timer selector.
package mux2_way_pkg;

  localparam int unsigned default_width   = 1;
  localparam int unsigned default_count_w = 8;

  // Mode select encoding used by the timer's mode-change logic.
  typedef enum logic {
    SEL_IN1 = 1'b0,
    SEL_IN2 = 1'b1
  } mode_sel_e;

endpackage

// File: rtl/mux2_way_core.sv
// Parameterized combinational two-input selector.
module mux2_way_core
  import mux2_way_pkg::*;
#(
  parameter int unsigned WIDTH = default_width
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  // Forward in1 for SEL_IN1, in2 for SEL_IN2; no clock or reset involvement.
  always_comb begin
    out = in1;
    case (mode_sel_e'(sel))
      SEL_IN1: out = in1;
      SEL_IN2: out = in2;
      default: out = in1;
    endcase
  end

endmodule

// File: rtl/mux2_way.sv
// Two-input mode selector with a registered copy of the output and
// select-change bookkeeping (pulse plus saturating counter).
module mux2_way
  import mux2_way_pkg::*;
#(
  parameter int unsigned WIDTH   = default_width,
  parameter int unsigned COUNT_W = default_count_w
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic               sel,
  output logic [WIDTH-1:0]   out,
  output logic [WIDTH-1:0]   out_q,
  output logic               sel_q,
  output logic               switch_pulse,
  output logic [COUNT_W-1:0] switch_count
);

  logic [WIDTH-1:0]   out_reg_q;
  logic               sel_reg_q;
  logic               pulse_q;
  logic               pulse_d;
  logic [COUNT_W-1:0] cnt_q;
  logic [COUNT_W-1:0] cnt_d;

  mux2_way_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .in1 (in1),
    .in2 (in2),
    .sel (sel),
    .out (out)
  );

  // A switch is a newly sampled sel that differs from the previous sample;
  // the counter holds at all-ones rather than wrapping.
  always_comb begin
    pulse_d = (sel != sel_reg_q);
    cnt_d   = cnt_q;
    if (pulse_d && (cnt_q != {COUNT_W{1'b1}})) begin
      cnt_d = cnt_q + COUNT_W'(1);
    end
  end

  // Registered side path, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_reg_q <= '0;
      sel_reg_q <= 1'b0;
      pulse_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      out_reg_q <= out;
      sel_reg_q <= sel;
      pulse_q   <= pulse_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_q        = out_reg_q;
  assign sel_q        = sel_reg_q;
  assign switch_pulse = pulse_q;
  assign switch_count = cnt_q;

endmodule

// File: tb/tb_mux2_way.sv
// Directed self-checking bench for mux2_way: an 8-bit instance and a 1-bit
// instance with a 2-bit counter share clock, reset and select.
module tb_mux2_way;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic [7:0] a8, b8, out8, out_q8, cnt8;
  logic       sel_q8, pulse8;
  logic       a1, b1, out1, out_q1, sel_q1, pulse1;
  logic [1:0] cnt1;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mux2_way #(
    .WIDTH   (8),
    .COUNT_W (8)
  ) dut8 (
    .clk          (clk),
    .rst          (rst),
    .in1          (a8),
    .in2          (b8),
    .sel          (sel),
    .out          (out8),
    .out_q        (out_q8),
    .sel_q        (sel_q8),
    .switch_pulse (pulse8),
    .switch_count (cnt8)
  );

  mux2_way #(
    .WIDTH   (1),
    .COUNT_W (2)
  ) dut1 (
    .clk          (clk),
    .rst          (rst),
    .in1          (a1),
    .in2          (b1),
    .sel          (sel),
    .out          (out1),
    .out_q        (out_q1),
    .sel_q        (sel_q1),
    .switch_pulse (pulse1),
    .switch_count (cnt1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    sel = 1'b0;
    a8  = 8'h00;
    b8  = 8'h00;
    a1  = 1'b0;
    b1  = 1'b0;
    #2;
    check("rst out_q", 32'(out_q8), 32'h0);
    check("rst sel_q", 32'(sel_q8), 32'h0);
    check("rst pulse", 32'(pulse8), 32'h0);
    check("rst count", 32'(cnt8), 32'h0);

    // Exhaustive 1-bit truth table, held in reset: out must still follow inputs.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v   = 3'(i);
      a1  = v[2];
      b1  = v[1];
      sel = v[0];
      for (int t = 0; t < 4; t++) begin
        #1;
        check("truth out", 32'(out1), 32'(v[0] ? v[1] : v[2]));
      end
      #1;
    end

    // 8-bit select with registered follow-up.
    @(negedge clk);
    rst = 1'b0;
    sel = 1'b0;
    a8  = 8'hA5;
    b8  = 8'h3C;
    #1;
    check("w8 out sel0", 32'(out8), 32'hA5);
    tick();
    check("w8 out_q sel0", 32'(out_q8), 32'hA5);
    check("no switch pulse", 32'(pulse8), 32'h0);
    check("no switch count", 32'(cnt8), 32'h0);
    @(negedge clk);
    sel = 1'b1;
    #1;
    check("w8 out sel1", 32'(out8), 32'h3C);
    check("w8 out_q lags", 32'(out_q8), 32'hA5);
    tick();
    check("w8 out_q sel1", 32'(out_q8), 32'h3C);
    check("sel_q 1", 32'(sel_q8), 32'h1);
    check("pulse 1st", 32'(pulse8), 32'h1);
    check("count 1", 32'(cnt8), 32'h1);
    @(negedge clk);
    sel = 1'b0;
    tick();
    check("count 2", 32'(cnt8), 32'h2);
    @(negedge clk);
    sel = 1'b1;
    tick();
    check("count 3", 32'(cnt8), 32'h3);

    // Mid-run asynchronous reset, away from any clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("async out_q", 32'(out_q8), 32'h0);
    check("async sel_q", 32'(sel_q8), 32'h0);
    check("async pulse", 32'(pulse8), 32'h0);
    check("async count", 32'(cnt8), 32'h0);
    check("async out", 32'(out8), 32'h3C);

    // Four consecutive toggles after release.
    @(negedge clk);
    rst = 1'b0;
    sel = 1'b0;
    tick();
    check("post-rst pulse", 32'(pulse8), 32'h0);
    check("post-rst count", 32'(cnt8), 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      sel = ~sel;
      tick();
      check("toggle pulse", 32'(pulse8), 32'h1);
      check("toggle count", 32'(cnt8), 32'(k + 1));
      check("sat count", 32'(cnt1), 32'((k + 1 > 3) ? 3 : k + 1));
    end

    // Hold sel for 10 cycles.
    for (int k = 0; k < 10; k++) begin
      tick();
      check("hold pulse", 32'(pulse8), 32'h0);
      check("hold count", 32'(cnt8), 32'h4);
    end

    // Fifth change: wide counter advances, 2-bit counter stays saturated.
    @(negedge clk);
    sel = ~sel;
    tick();
    check("5th count", 32'(cnt8), 32'h5);
    check("5th sat count", 32'(cnt1), 32'h3);
    check("5th sat pulse", 32'(pulse1), 32'h1);
    tick();
    check("pulse one cycle", 32'(pulse8), 32'h0);

    // sel=1 on the first sample after reset counts as a switch.
    #2;
    rst = 1'b1;
    @(negedge clk);
    sel = 1'b1;
    rst = 1'b0;
    tick();
    check("first sample pulse", 32'(pulse8), 32'h1);
    check("first sample count", 32'(cnt8), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux2_way.md
# mux2_way

Two-input selector for the two-mode timer: drives one of two mode signals onto a shared output under control of a select line. The combinational path forwards `in1` when `sel`=0 and `in2` when `sel`=1 with no clock latency. A clocked side path provides a registered copy of the output and switch-event bookkeeping for the timer's mode-change logic.

## Interface
Parameters:
- `WIDTH`, 1: bit width of `in1`, `in2`, `out`, `out_q`.
- `COUNT_W`, 8: width of the `switch_count` counter.

Ports:
- `clk`, input, 1: single system clock; all registers sample on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high; clears all registers immediately.
- `in1`, input, WIDTH: data input selected when `sel`=0.
- `in2`, input, WIDTH: data input selected when `sel`=1.
- `sel`, input, 1: select line.
- `out`, output, WIDTH: combinational result, `sel ? in2 : in1`.
- `out_q`, output, WIDTH: `out` registered one cycle.
- `sel_q`, output, 1: `sel` registered one cycle.
- `switch_pulse`, output, 1: one-cycle pulse when the registered select changes value.
- `switch_count`, output, COUNT_W: saturating count of select changes since reset.

## Operation
- `out` is purely combinational and independent of `clk` and `rst`.
  - `sel`=0: `out` = `in1`, bit for bit.
  - `sel`=1: `out` = `in2`.
  - `out` remains valid and correct while `rst` is asserted.
- Each rising `clk` edge with `rst` low:
  - `out_q` <= `out`.
  - `sel_q` <= `sel`.
  - `switch_pulse` <= (`sel` != `sel_q`).
  - `switch_count` increments when `sel` != `sel_q`.
- `switch_count` saturates at all-ones and never wraps.
- There is no state machine. The only state is the `out_q`/`sel_q` pipeline and the counter.
- No enable or handshake; the selector is always active.

## Timing
- `out`: zero-cycle latency. It settles within one combinational delay of any change on `in1`, `in2` or `sel`. It must be correct 1 ns after any input change in simulation.
- `out_q`, `sel_q`: one-cycle latency.
- `switch_pulse`: asserted for exactly one cycle, in the cycle after `sel_q` would differ from the newly sampled `sel`.
- Reset values, applied asynchronously on `rst` rising:
  - `out_q` = 0, `sel_q` = 0, `switch_pulse` = 0, `switch_count` = 0.
- First cycle after reset release: a `sel`=1 sample counts as a switch, because `sel_q` was 0.
- Reset mid-operation: registers clear immediately; `out` keeps following the inputs.
- `sel` toggling faster than `clk`: only toggles visible at sampling edges are counted.

## Structure
- Shared package `mux2_way_pkg` holds:
  - default `WIDTH` and `COUNT_W` constants;
  - a `mode_sel_e` enum: `SEL_IN1`=0, `SEL_IN2`=1, used by the timer's mode logic.
- One natural sub-module: `mux2_way_core`, the parameterized combinational selector. The top level instantiates it and adds the registered side path.

## Test plan
- Exhaustive truth table, `WIDTH`=1, 5 ns per vector, all 8 combinations of `in1`/`in2`/`sel` -> `out` equals `in1` when `sel`=0 and `in2` when `sel`=1. Check every 1 ns.
- `WIDTH`=8, `in1`=0xA5, `in2`=0x3C, `sel`=0 then 1 -> `out`=0xA5 then 0x3C immediately; `out_q` follows one edge later.
- Reset: assert `rst` mid-run with `switch_count`=3 -> `out_q`, `sel_q`, `switch_pulse`, `switch_count` are 0 at once, before any clock edge. `out` is still correct.
- Toggle `sel` on 4 consecutive clock samples -> 4 single-cycle `switch_pulse` assertions, `switch_count`=4.
- `COUNT_W`=2, 5 select changes -> `switch_count` stops at 3.
- Hold `sel` constant for 10 cycles -> `switch_pulse` stays 0 and `switch_count` is unchanged.
